// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t          : loader FSM encoding (IDLE/LOAD/RUN/ERR)
//   MEMORY_SIZE_DEF  : default instruction memory depth in bytes
//   TIMEOUT_DEF      : default idle-cycle budget between stream bytes
//   len_legal()      : load-length check applied whenever Start is accepted
package imem_boot_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  localparam int unsigned MEMORY_SIZE_DEF = 1024;
  localparam int unsigned TIMEOUT_DEF     = 65535;

  // A load must carry at least one byte and must fit in the memory.
  function automatic logic len_legal(input logic [31:0] len,
                                     input int unsigned mem_size);
    return (len != 32'd0) && (len <= 32'(mem_size));
  endfunction

endpackage

// File: rtl/imem_boot_loader_port_mux.sv
// Instruction memory port steering for the boot loader.
// The read address belongs to the core only while running; the write port
// belongs to the loader only while loading. Everything else is parked at 0.
// Ports:
//   state       : current loader state
//   wr_allow    : 0 suppresses writes (reset asserted)
//   pc_addr     : core fetch address
//   in_valid    : stream byte valid (loader is always ready in LOAD)
//   in_data     : stream byte
//   count       : next byte address within the load
//   mem_rd_addr : instruction memory read address
//   mem_we      : byte write enable
//   mem_waddr   : byte write address
//   mem_wdata   : byte write data
module imem_port_mux
  import imem_boot_loader_pkg::*;
(
  input  state_t      state,
  input  logic        wr_allow,
  input  logic [31:0] pc_addr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [31:0] count,
  output logic [31:0] mem_rd_addr,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [7:0]  mem_wdata
);

  always_comb begin
    mem_rd_addr = 32'd0;
    mem_we      = 1'b0;
    mem_waddr   = 32'd0;
    mem_wdata   = 8'd0;
    if (state == ST_RUN) begin
      mem_rd_addr = pc_addr;
    end
    if (state == ST_LOAD) begin
      // A reset landing mid-load must not commit one last byte on its edge.
      mem_we    = in_valid & wr_allow;
      mem_waddr = count;
      mem_wdata = in_data;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for the byte-addressed instruction memory.
// Accepts a program as a valid/ready byte stream, writes it to memory while
// holding the core, then releases the core and hands it the read port.
// Ports:
//   Clk, Reset     : clock, synchronous active-low reset
//   Start, Len     : begin a load of Len bytes (Len sampled with Start)
//   In_Valid/Ready : byte stream handshake, In_Data carries the byte
//   PC_Addr        : core fetch address, forwarded while running
//   Mem_RD_Addr    : memory read address
//   Mem_WE/WAddr/WData : memory byte write port
//   Core_Run       : core may execute
//   Load_Done      : one-cycle pulse on completion of a load
//   Error          : sticky; illegal length or stream timeout
//   Checksum       : mod-256 sum of bytes written by the current/last load
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned MEMORY_SIZE = MEMORY_SIZE_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [31:0] Len,
  input  logic        In_Valid,
  input  logic [7:0]  In_Data,
  output logic        In_Ready,
  input  logic [31:0] PC_Addr,
  output logic [31:0] Mem_RD_Addr,
  output logic        Mem_WE,
  output logic [31:0] Mem_WAddr,
  output logic [7:0]  Mem_WData,
  output logic        Core_Run,
  output logic        Load_Done,
  output logic        Error,
  output logic [7:0]  Checksum
);

  state_t      state;
  logic [31:0] count;
  logic [31:0] idle;
  logic [31:0] len_q;
  logic [31:0] idle_nxt;
  logic        handshake;
  logic        last_byte;

  assign In_Ready  = (state == ST_LOAD);
  assign handshake = In_Valid & In_Ready;
  assign idle_nxt  = idle + 32'd1;
  assign last_byte = (count == len_q - 32'd1);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      count     <= 32'd0;
      idle      <= 32'd0;
      Checksum  <= 8'd0;
      Error     <= 1'b0;
      Load_Done <= 1'b0;
      Core_Run  <= 1'b0;
    end else begin
      Load_Done <= 1'b0;
      case (state)
        ST_IDLE, ST_ERR, ST_RUN: begin
          if (Start) begin
            Core_Run <= 1'b0;
            if (len_legal(Len, MEMORY_SIZE)) begin
              state    <= ST_LOAD;
              count    <= 32'd0;
              idle     <= 32'd0;
              Checksum <= 8'd0;
              Error    <= 1'b0;
              len_q    <= Len;
            end else begin
              state <= ST_ERR;
              Error <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            Checksum <= Checksum + In_Data;
            idle     <= 32'd0;
            if (last_byte) begin
              // count stays at Len-1 so the write address never runs past the load.
              state     <= ST_RUN;
              Load_Done <= 1'b1;
              Core_Run  <= 1'b1;
            end else begin
              count <= count + 32'd1;
            end
          end else begin
            idle <= idle_nxt;
            if (idle_nxt >= 32'(TIMEOUT)) begin
              state <= ST_ERR;
              Error <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  imem_port_mux u_port_mux (
    .state       (state),
    .wr_allow    (Reset),
    .pc_addr     (PC_Addr),
    .in_valid    (In_Valid),
    .in_data     (In_Data),
    .count       (count),
    .mem_rd_addr (Mem_RD_Addr),
    .mem_we      (Mem_WE),
    .mem_waddr   (Mem_WAddr),
    .mem_wdata   (Mem_WData)
  );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader (TIMEOUT shortened to 8).
module tb_imem_boot_loader;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [31:0] Len;
  logic        In_Valid;
  logic [7:0]  In_Data;
  logic        In_Ready;
  logic [31:0] PC_Addr;
  logic [31:0] Mem_RD_Addr;
  logic        Mem_WE;
  logic [31:0] Mem_WAddr;
  logic [7:0]  Mem_WData;
  logic        Core_Run;
  logic        Load_Done;
  logic        Error;
  logic [7:0]  Checksum;

  int n_assert = 0;
  int n_fail   = 0;

  // Write recorder: what the instruction memory would have received.
  logic [7:0]  bench_mem [0:1023];
  int          wr_cnt = 0;
  int          wr_oob = 0;
  logic [31:0] last_waddr = 32'd0;

  logic [7:0] vec4 [4] = '{8'h93, 8'h00, 8'h80, 8'h3e};

  imem_boot_loader #(
    .MEMORY_SIZE (1024),
    .TIMEOUT     (8)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Len         (Len),
    .In_Valid    (In_Valid),
    .In_Data     (In_Data),
    .In_Ready    (In_Ready),
    .PC_Addr     (PC_Addr),
    .Mem_RD_Addr (Mem_RD_Addr),
    .Mem_WE      (Mem_WE),
    .Mem_WAddr   (Mem_WAddr),
    .Mem_WData   (Mem_WData),
    .Core_Run    (Core_Run),
    .Load_Done   (Load_Done),
    .Error       (Error),
    .Checksum    (Checksum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Mem_WE === 1'b1) begin
      wr_cnt++;
      last_waddr = Mem_WAddr;
      if (Mem_WAddr < 32'd1024) bench_mem[Mem_WAddr[9:0]] = Mem_WData;
      else wr_oob++;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "time limit expired");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; Len = 32'd0; In_Valid = 1'b0; In_Data = 8'd0;
    PC_Addr = 32'h44;
    tick; tick;
    Reset = 1'b1; #1;
    chk("rst_core_run",  Core_Run, 0);
    chk("rst_load_done", Load_Done, 0);
    chk("rst_error",     Error, 0);
    chk("rst_checksum",  Checksum, 0);
    chk("rst_in_ready",  In_Ready, 0);
    chk("rst_mem_we",    Mem_WE, 0);
    chk("rst_rd_addr",   Mem_RD_Addr, 0);

    // Normal load of four bytes
    Start = 1'b1; Len = 32'd4; tick; Start = 1'b0; Len = 32'd0; #1;
    chk("load_in_ready", In_Ready, 1);
    chk("load_core_held", Core_Run, 0);
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1'b1; In_Data = vec4[i]; #1;
      chk("load_we", Mem_WE, 1);
      chk("load_waddr", Mem_WAddr, 32'(i));
      chk("load_wdata", Mem_WData, {24'd0, vec4[i]});
      tick;
    end
    In_Valid = 1'b0; #1;
    chk("load_done_pulse", Load_Done, 1);
    chk("load_core_run", Core_Run, 1);
    chk("load_checksum", Checksum, 32'h51);
    chk("load_wr_cnt", wr_cnt, 4);
    chk("load_mem0", bench_mem[0], 32'h93);
    chk("load_mem3", bench_mem[3], 32'h3e);
    PC_Addr = 32'h10; In_Valid = 1'b1; In_Data = 8'hEE; #1;
    chk("run_rd_addr", Mem_RD_Addr, 32'h10);
    chk("run_in_ready", In_Ready, 0);
    chk("run_we", Mem_WE, 0);
    tick; In_Valid = 1'b0; #1;
    chk("run_done_once", Load_Done, 0);
    chk("run_core_run", Core_Run, 1);
    chk("run_wr_cnt", wr_cnt, 4);

    // Length errors, then recovery with a legal one-byte load
    Start = 1'b1; Len = 32'd0; tick; Start = 1'b0; #1;
    chk("len0_error", Error, 1);
    chk("len0_core_run", Core_Run, 0);
    chk("len0_in_ready", In_Ready, 0);
    chk("len0_rd_addr", Mem_RD_Addr, 0);
    chk("len0_checksum", Checksum, 32'h51);
    Start = 1'b1; Len = 32'd1025; tick; Start = 1'b0; #1;
    chk("len1025_error", Error, 1);
    chk("len1025_in_ready", In_Ready, 0);
    chk("len1025_wr_cnt", wr_cnt, 4);
    Start = 1'b1; Len = 32'd1; tick; Start = 1'b0; #1;
    chk("len1_error_clr", Error, 0);
    chk("len1_in_ready", In_Ready, 1);
    chk("len1_checksum", Checksum, 0);
    In_Valid = 1'b1; In_Data = 8'hA5; tick; In_Valid = 1'b0; #1;
    chk("len1_core_run", Core_Run, 1);
    chk("len1_done", Load_Done, 1);
    chk("len1_checksum2", Checksum, 32'hA5);
    chk("len1_wr_cnt", wr_cnt, 5);

    // Stream with 5-cycle gaps completes
    Start = 1'b1; Len = 32'd3; tick; Start = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      In_Valid = 1'b1; In_Data = 8'(b); tick; In_Valid = 1'b0;
      if (b < 3) repeat (5) tick;
    end
    #1;
    chk("gap_core_run", Core_Run, 1);
    chk("gap_checksum", Checksum, 32'h06);
    chk("gap_error", Error, 0);
    chk("gap_mem2", bench_mem[2], 32'h03);
    chk("gap_wr_cnt", wr_cnt, 8);

    // Stall of TIMEOUT cycles after the second byte
    Start = 1'b1; Len = 32'd3; tick; Start = 1'b0;
    In_Valid = 1'b1; In_Data = 8'h10; tick;
    In_Data = 8'h20; tick;
    In_Valid = 1'b0;
    repeat (7) tick;
    #1;
    chk("stall7_in_ready", In_Ready, 1);
    chk("stall7_error", Error, 0);
    tick; #1;
    chk("tmo_error", Error, 1);
    chk("tmo_core_run", Core_Run, 0);
    chk("tmo_in_ready", In_Ready, 0);
    chk("tmo_checksum", Checksum, 32'h30);
    chk("tmo_wr_cnt", wr_cnt, 10);

    // Reset in the middle of a load
    Start = 1'b1; Len = 32'd8; tick; Start = 1'b0;
    In_Valid = 1'b1; In_Data = 8'h11; tick;
    In_Data = 8'h22; tick;
    In_Data = 8'h33; tick;
    In_Valid = 1'b0; Reset = 1'b0; tick;
    In_Valid = 1'b1; In_Data = 8'h44; #1;
    chk("mrst_in_ready", In_Ready, 0);
    chk("mrst_checksum", Checksum, 0);
    chk("mrst_we", Mem_WE, 0);
    chk("mrst_error", Error, 0);
    chk("mrst_core_run", Core_Run, 0);
    chk("mrst_wr_cnt", wr_cnt, 13);

    // Start and In_Valid together in IDLE: that byte is dropped
    Reset = 1'b1; Start = 1'b1; Len = 32'd2; #1;
    chk("idle_sv_in_ready", In_Ready, 0);
    chk("idle_sv_we", Mem_WE, 0);
    tick; Start = 1'b0; In_Data = 8'hAA; #1;
    chk("idle_sv_waddr0", Mem_WAddr, 0);
    chk("idle_sv_we1", Mem_WE, 1);
    tick; In_Data = 8'hBB; tick; In_Valid = 1'b0; #1;
    chk("idle_sv_checksum", Checksum, 32'h65);
    chk("idle_sv_core_run", Core_Run, 1);
    chk("idle_sv_mem1", bench_mem[1], 32'hBB);
    chk("idle_sv_wr_cnt", wr_cnt, 15);

    // Reload from RUN
    PC_Addr = 32'h1C; #1;
    chk("reload_rd_pc", Mem_RD_Addr, 32'h1C);
    Start = 1'b1; Len = 32'd2; tick; Start = 1'b0; #1;
    chk("reload_core_held", Core_Run, 0);
    chk("reload_rd_zero", Mem_RD_Addr, 0);
    chk("reload_in_ready", In_Ready, 1);
    In_Valid = 1'b1; In_Data = 8'h5A; #1;
    chk("reload_waddr0", Mem_WAddr, 0);
    tick; In_Data = 8'hC3; #1;
    chk("reload_waddr1", Mem_WAddr, 1);
    tick; In_Valid = 1'b0; #1;
    chk("reload_core_run", Core_Run, 1);
    chk("reload_mem0", bench_mem[0], 32'h5A);
    chk("reload_mem1", bench_mem[1], 32'hC3);
    chk("reload_checksum", Checksum, 32'h1D);
    chk("reload_wr_cnt", wr_cnt, 17);

    // Full-size load
    Start = 1'b1; Len = 32'd1024; tick; Start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      In_Valid = 1'b1; In_Data = 8'(i);
      if (i == 1023) begin
        #1;
        chk("full_last_waddr_live", Mem_WAddr, 32'd1023);
      end
      tick;
    end
    In_Valid = 1'b0; #1;
    chk("full_last_waddr", last_waddr, 32'd1023);
    chk("full_oob", wr_oob, 0);
    chk("full_checksum", Checksum, 32'h00);
    chk("full_core_run", Core_Run, 1);
    chk("full_done", Load_Done, 1);
    chk("full_mem1023", bench_mem[1023], 32'hFF);
    chk("full_mem256", bench_mem[256], 32'h00);
    chk("full_wr_cnt", wr_cnt, 1041);
    chk("full_we_off", Mem_WE, 0);
    chk("full_error", Error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Loads program bytes into the byte-addressed instruction memory from an external valid/ready byte stream.
- Holds the core in a non-running state while loading; releases it once the load completes.
- Owns the memory address mux: the loader's write address during load, the core's PC read address during run.
- Sits between the board-level loader link (UART/JTAG bridge) and the instruction memory.

Parameters:
- MEMORY_SIZE, 1024, instruction memory depth in bytes; the maximum legal load length.
- TIMEOUT, 65535, idle cycles allowed between stream bytes in LOAD before aborting.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset (0 = reset, sampled on Clk rising edge).
- Start  input  1  single-cycle pulse that begins a load.
- Len  input  32  byte count to load; sampled when Start is accepted.
- In_Valid  input  1  stream byte valid.
- In_Data  input  8  stream byte.
- In_Ready  output  1  loader accepts a byte this cycle.
- PC_Addr  input  32  core fetch address.
- Mem_RD_Addr  output  32  instruction memory read address.
- Mem_WE  output  1  instruction memory byte write enable.
- Mem_WAddr  output  32  instruction memory byte write address.
- Mem_WData  output  8  instruction memory write byte.
- Core_Run  output  1  1 = core may fetch/execute; 0 = core held.
- Load_Done  output  1  one-cycle pulse on LOAD->RUN.
- Error  output  1  sticky error flag.
- Checksum  output  8  mod-256 sum of bytes written in the current/last load.

Behaviour:
- States: IDLE=2'b00, LOAD=2'b01, RUN=2'b10, ERR=2'b11.
- Reset (Reset==0 at edge):
  - state=IDLE; byte count, idle counter, Checksum, Error, Load_Done, Core_Run all 0.
  - Reset mid-load aborts immediately; no further writes.
- IDLE or ERR, Start==1:
  - Len==0 or Len>MEMORY_SIZE -> ERR with Error=1.
  - Otherwise -> LOAD with count=0, Checksum=0, idle=0, Error=0, and latch Len.
- IDLE or ERR, Start==0: hold state.
- LOAD:
  - In_Ready=1.
  - Handshake = In_Valid & In_Ready.
  - Write port is combinational, same cycle as handshake: Mem_WE=In_Valid, Mem_WAddr=count, Mem_WData=In_Data.
  - On handshake: count+=1, Checksum+=In_Data (wraps mod 256), idle=0.
  - No handshake: idle+=1; when idle reaches TIMEOUT -> ERR with Error=1, and count/Checksum retain their values.
  - Handshake with count==Len-1 -> RUN. Load_Done=1 for the first RUN cycle only; Core_Run=1 from that cycle on.
  - Start during LOAD is ignored.
- RUN:
  - Mem_RD_Addr=PC_Addr (combinational pass-through).
  - In_Ready=0, Mem_WE=0.
  - Start==1 -> same length check as in IDLE. Core_Run drops to 0 in the next cycle; next state is LOAD or ERR.
- Outside RUN: Mem_RD_Addr=0, Core_Run=0.
- Outside LOAD: Mem_WE=0, Mem_WAddr=0, Mem_WData=0.
- Boundaries:
  - Len==MEMORY_SIZE is legal; the last write goes to address MEMORY_SIZE-1.
  - count never exceeds Len-1, so there is no address wrap.
  - In_Valid in IDLE, RUN or ERR is not accepted (In_Ready=0).
  - Start and In_Valid in the same IDLE cycle: the byte is not accepted.
  - Error clears only on reset or on an accepted legal Start.
  - Core_Run is registered (driven from state), so it never glitches.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/LOAD/RUN/ERR);
  - MEMORY_SIZE default;
  - TIMEOUT default.
- One natural sub-module: imem_port_mux. It selects Mem_RD_Addr and the write-port signals from state, PC_Addr and the loader fields.
- FSM, counters and checksum stay in the top module.

Test Plan:
- Normal load: Reset low 2 cycles; Start, Len=4; stream 93,00,80,3e with In_Valid held.
  - Writes to addresses 0..3 on 4 consecutive cycles.
  - Checksum=0x51; Load_Done pulses once; Core_Run=1.
  - PC_Addr=0x10 then appears on Mem_RD_Addr.
- Length errors:
  - Start with Len=0 -> Error=1, state ERR, no writes.
  - Start with Len=1025 -> same response.
  - Then Start with Len=1 and one byte -> Error=0, Core_Run=1.
- Stream gaps and timeout, with TIMEOUT=8, Len=3:
  - Bytes with 5-cycle gaps -> load completes.
  - Stall 8 cycles after byte 2 -> ERR, Error=1, Core_Run=0, no third write.
- Reset mid-load: Len=8; assert Reset after 3 bytes.
  - Next cycle: IDLE, In_Ready=0, Checksum=0, Mem_WE=0 even with In_Valid=1.
- Reload from RUN: in RUN with PC_Addr=0x1C, pulse Start with Len=2.
  - Core_Run=0 and Mem_RD_Addr=0 next cycle.
  - Two bytes rewrite addresses 0..1; Core_Run returns to 1.
- Full size: Len=1024, bytes i mod 256.
  - Last write at address 1023; Checksum=0x00; no write at 1024.
